ntsc_dac_arbiter: RTL

Shares the single ADV7123 video DAC between two full NTSC video sources: source 0 is the free-running colorbar generator, which is also the timing master; source 1 is an external frame source slaved to the same timing. The block arbitrates requests round-robin with a minimum hold time and switches ownership only at frame boundaries, so no field is ever torn. It drives the registered RGB/BLANK_N/SYNC_N pins of the DAC.

---
 rtl/ntsc_pkg.sv | 26 ++
 rtl/ntsc_rr_frame_fsm.sv | 93 +++++++++
 rtl/ntsc_dac_arbiter.sv | 92 +++++++++
 3 files changed

// File: rtl/ntsc_pkg.sv
// Shared NTSC arbiter definitions: state encodings, DAC blank-level values and raster constants.
package ntsc_pkg;

    localparam int DW_DEF  = 10;
    localparam int H_TOTAL = 6360;
    localparam int V_TOTAL = 525;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_OWN0 = 2'd1,
        ST_OWN1 = 2'd2
    } arb_state_t;

    // DAC pin levels that show black with no sync pulse.
    localparam logic BLANK_N_BLANK = 1'b0;
    localparam logic SYNC_N_BLANK  = 1'b1;

    function automatic int hold_width(input int frames);
        return (frames > 1) ? $clog2(frames) : 1;
    endfunction

    function automatic logic [1:0] gnt_of_state(input arb_state_t s);
        return {s == ST_OWN1, s == ST_OWN0};
    endfunction

endpackage

// File: rtl/ntsc_rr_frame_fsm.sv
// Round-robin DAC ownership FSM that only re-evaluates on frame_start,
// with a minimum hold time while the other source is waiting.
//
//   state   | meaning
//   IDLE    | nobody owns the DAC; outputs sit at blank with source 0 sync
//   OWN0    | colorbar generator drives the DAC
//   OWN1    | external frame source drives the DAC
module ntsc_rr_frame_fsm
    import ntsc_pkg::*;
#(
    parameter int HOLD_FRAMES = 60
) (
    input  logic       sclk,
    input  logic       rst_n,
    input  logic       frame_start,
    input  logic [1:0] req,
    output logic [1:0] gnt,
    output logic       gnt_chg
);

    localparam int HW = hold_width(HOLD_FRAMES);
    localparam logic [HW-1:0] HOLD_MAX = HW'(HOLD_FRAMES - 1);

    arb_state_t      state;
    arb_state_t      state_next;
    logic            last_owner;
    logic [HW-1:0]   hold_cnt;
    logic            hold_done;

    assign hold_done = (hold_cnt == HOLD_MAX);

    always_comb begin
        state_next = state;
        if (frame_start) begin
            unique case (state)
                ST_IDLE: begin
                    unique case (req)
                        2'b01:   state_next = ST_OWN0;
                        2'b10:   state_next = ST_OWN1;
                        2'b11:   state_next = last_owner ? ST_OWN0 : ST_OWN1;
                        default: state_next = ST_IDLE;
                    endcase
                end
                ST_OWN0: begin
                    if (!req[0]) begin
                        state_next = req[1] ? ST_OWN1 : ST_IDLE;
                    end else if (req[1] && hold_done) begin
                        state_next = ST_OWN1;
                    end
                end
                ST_OWN1: begin
                    if (!req[1]) begin
                        state_next = req[0] ? ST_OWN0 : ST_IDLE;
                    end else if (req[0] && hold_done) begin
                        state_next = ST_OWN0;
                    end
                end
                default: state_next = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge sclk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            gnt        <= 2'b00;
            gnt_chg    <= 1'b0;
            last_owner <= 1'b1;
            hold_cnt   <= '0;
        end else begin
            state   <= state_next;
            gnt     <= gnt_of_state(state_next);
            gnt_chg <= (state_next != state);

            if (state_next != state) begin
                if (state_next == ST_OWN0) begin
                    last_owner <= 1'b0;
                end else if (state_next == ST_OWN1) begin
                    last_owner <= 1'b1;
                end
            end

            // Counter restarts on every handover and saturates so a long
            // uncontested ownership switches on the first contested frame.
            if ((state_next != state) || (state_next == ST_IDLE)) begin
                hold_cnt <= '0;
            end else if (frame_start && !hold_done) begin
                hold_cnt <= hold_cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/ntsc_dac_arbiter.sv
// Shares one ADV7123 DAC between the colorbar generator and an external
// source; ownership changes only at frame boundaries, pins are registered.
module ntsc_dac_arbiter
    import ntsc_pkg::*;
#(
    parameter int DW          = DW_DEF,
    parameter int HOLD_FRAMES = 60
) (
    input  logic          sclk,
    input  logic          rst_n,
    input  logic          frame_start,
    input  logic [1:0]    req,
    input  logic [DW-1:0] src0_red,
    input  logic [DW-1:0] src0_green,
    input  logic [DW-1:0] src0_blue,
    input  logic          src0_blank_n,
    input  logic          src0_sync_n,
    input  logic [DW-1:0] src1_red,
    input  logic [DW-1:0] src1_green,
    input  logic [DW-1:0] src1_blue,
    input  logic          src1_blank_n,
    input  logic          src1_sync_n,
    output logic [1:0]    gnt,
    output logic          gnt_chg,
    output logic [DW-1:0] red,
    output logic [DW-1:0] green,
    output logic [DW-1:0] blue,
    output logic          blank_n,
    output logic          sync_n
);

    logic [DW-1:0] mux_red;
    logic [DW-1:0] mux_green;
    logic [DW-1:0] mux_blue;
    logic          mux_blank_n;
    logic          mux_sync_n;

    ntsc_rr_frame_fsm #(
        .HOLD_FRAMES (HOLD_FRAMES)
    ) u_fsm (
        .sclk        (sclk),
        .rst_n       (rst_n),
        .frame_start (frame_start),
        .req         (req),
        .gnt         (gnt),
        .gnt_chg     (gnt_chg)
    );

    // Mux keys off the pre-edge grant, so the switching edge still carries
    // the old owner's sample and the new owner appears one edge later.
    always_comb begin
        mux_red     = '0;
        mux_green   = '0;
        mux_blue    = '0;
        mux_blank_n = BLANK_N_BLANK;
        mux_sync_n  = src0_sync_n;
        unique case (gnt)
            2'b01: begin
                mux_red     = src0_red;
                mux_green   = src0_green;
                mux_blue    = src0_blue;
                mux_blank_n = src0_blank_n;
                mux_sync_n  = src0_sync_n;
            end
            2'b10: begin
                mux_red     = src1_red;
                mux_green   = src1_green;
                mux_blue    = src1_blue;
                mux_blank_n = src1_blank_n;
                mux_sync_n  = src1_sync_n;
            end
            default: ;
        endcase
    end

    always_ff @(posedge sclk or negedge rst_n) begin
        if (!rst_n) begin
            red     <= '0;
            green   <= '0;
            blue    <= '0;
            blank_n <= BLANK_N_BLANK;
            sync_n  <= SYNC_N_BLANK;
        end else begin
            red     <= mux_red;
            green   <= mux_green;
            blue    <= mux_blue;
            blank_n <= mux_blank_n;
            sync_n  <= mux_sync_n;
        end
    end

endmodule
